// File: rtl/vector_alu_pkg.sv
// Shared definitions for the vector ALU pipeline.
//   valu_op_e   : opcode shared by all lanes
//   CMP_*       : compare-condition codes consumed by the comparison unit
//   lane_lsb()  : bit offset of a lane inside a packed lane vector
package vector_alu_pkg;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      MUL  = 4'd2,
      FADD = 4'd3,
      FSUB = 4'd4,
      FMUL = 4'd5,
      AND  = 4'd6,
      OR   = 4'd7,
      XOR  = 4'd8,
      NOT  = 4'd9,
      CMP  = 4'd10
   } valu_op_e;

   // Signed compares treat elements as two's complement; *U variants are unsigned.
   localparam logic [3:0] CMP_EQ  = 4'd0;
   localparam logic [3:0] CMP_NE  = 4'd1;
   localparam logic [3:0] CMP_LT  = 4'd2;
   localparam logic [3:0] CMP_LE  = 4'd3;
   localparam logic [3:0] CMP_GT  = 4'd4;
   localparam logic [3:0] CMP_GE  = 4'd5;
   localparam logic [3:0] CMP_LTU = 4'd6;
   localparam logic [3:0] CMP_LEU = 4'd7;
   localparam logic [3:0] CMP_GTU = 4'd8;
   localparam logic [3:0] CMP_GEU = 4'd9;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/vector_alu_pipe_lane.sv
// valu_lane: one combinational ALU lane.
//   op, cmp   : shared opcode and compare condition
//   use_c     : selects C instead of B as the second operand
//   mask      : 1 = lane active; 0 = pass C through, predicate 0
//   a, b, c   : lane operands
//   result    : lane result
//   pred      : compare predicate (only ever set by CMP)
// FP32 units: round-to-nearest-even, subnormal inputs/outputs flushed to
// signed zero, overflow to infinity, any NaN produces the canonical quiet NaN.
module valu_lane
   import vector_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  valu_op_e         op,
   input  logic [3:0]       cmp,
   input  logic             use_c,
   input  logic             mask,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] result,
   output logic             pred
);

   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic              sgn, g, s;
      logic [23:0]       mx, my, mant;
      logic [47:0]       prod;
      logic [24:0]       rnd;
      logic signed [9:0] ex;
      logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
      x_zero = (x[30:23] == 8'h00);
      y_zero = (y[30:23] == 8'h00);
      x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      sgn    = x[31] ^ y[31];
      if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return FP_QNAN;
      if (x_inf || y_inf) return {sgn, 8'hFF, 23'd0};
      if (x_zero || y_zero) return {sgn, 31'd0};
      mx   = {1'b1, x[22:0]};
      my   = {1'b1, y[22:0]};
      prod = {24'd0, mx} * {24'd0, my};
      ex   = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
      // Product of two [1,2) mantissas lies in [1,4): normalise by at most one bit.
      if (prod[47]) begin
         mant = prod[47:24];
         g    = prod[23];
         s    = |prod[22:0];
         ex   = ex + 10'sd1;
      end else begin
         mant = prod[46:23];
         g    = prod[22];
         s    = |prod[21:0];
      end
      rnd = {1'b0, mant} + {24'd0, g & (s | mant[0])};
      if (rnd[24]) begin
         rnd = {1'b0, rnd[24:1]};
         ex  = ex + 10'sd1;
      end
      if (ex >= 10'sd255) return {sgn, 8'hFF, 23'd0};
      if (ex <= 10'sd0)   return {sgn, 31'd0};
      return {sgn, ex[7:0], rnd[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic              x_inf, y_inf, x_nan, y_nan, swap, sgn, st, g, s;
      logic [31:0]       big, sml;
      logic [23:0]       big_m, sml_m;
      logic [7:0]        d;
      logic [26:0]       ext, al;
      logic [27:0]       sum;
      logic [24:0]       rnd;
      logic signed [9:0] e;
      x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) return FP_QNAN;
      if (x_inf) return x;
      if (y_inf) return y;
      // Order by magnitude so the subtraction below never goes negative.
      swap  = (x[30:0] < y[30:0]);
      big   = swap ? y : x;
      sml   = swap ? x : y;
      big_m = (big[30:23] == 8'h00) ? 24'd0 : {1'b1, big[22:0]};
      sml_m = (sml[30:23] == 8'h00) ? 24'd0 : {1'b1, sml[22:0]};
      sgn   = big[31];
      d     = big[30:23] - sml[30:23];
      // Three extra bits (guard, round, sticky) below the mantissa.
      ext   = {sml_m, 3'b000};
      if (d > 8'd26) begin
         al = 27'd0;
         st = |sml_m;
      end else begin
         al = ext >> d;
         st = |(ext & ~({27{1'b1}} << d));
      end
      al[0] = al[0] | st;
      if (x[31] ^ y[31]) sum = {1'b0, big_m, 3'b000} - {1'b0, al};
      else               sum = {1'b0, big_m, 3'b000} + {1'b0, al};
      if (sum == 28'd0) return 32'd0;   // exact cancellation rounds to +0
      e = $signed({2'b00, big[30:23]});
      if (sum[27]) begin
         sum = {1'b0, sum[27:2], sum[1] | sum[0]};
         e   = e + 10'sd1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!sum[26]) begin
               sum = sum << 1;
               e   = e - 10'sd1;
            end
         end
      end
      g   = sum[2];
      s   = |sum[1:0];
      rnd = {1'b0, sum[26:3]} + {24'd0, g & (s | sum[3])};
      if (rnd[24]) begin
         rnd = {1'b0, rnd[24:1]};
         e   = e + 10'sd1;
      end
      if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
      if (e <= 10'sd0)   return {sgn, 31'd0};
      return {sgn, e[7:0], rnd[22:0]};
   endfunction

   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] fadd_res, fsub_res, fmul_res;
   logic [WIDTH-1:0] op_res;
   logic             cmp_true;
   logic             op_pred;

   assign opnd_b = use_c ? c : b;

   generate
      if (WIDTH == 32) begin : g_fp
         assign fadd_res = fp_add(a, opnd_b);
         assign fsub_res = fp_add(a, {~opnd_b[WIDTH-1], opnd_b[WIDTH-2:0]});
         assign fmul_res = fp_mul(a, opnd_b);
      end else begin : g_no_fp
         assign fadd_res = '0;
         assign fsub_res = '0;
         assign fmul_res = '0;
      end
   endgenerate

   always_comb begin
      cmp_true = 1'b0;
      case (cmp)
         CMP_EQ:  cmp_true = (a == opnd_b);
         CMP_NE:  cmp_true = (a != opnd_b);
         CMP_LT:  cmp_true = ($signed(a) <  $signed(opnd_b));
         CMP_LE:  cmp_true = ($signed(a) <= $signed(opnd_b));
         CMP_GT:  cmp_true = ($signed(a) >  $signed(opnd_b));
         CMP_GE:  cmp_true = ($signed(a) >= $signed(opnd_b));
         CMP_LTU: cmp_true = (a <  opnd_b);
         CMP_LEU: cmp_true = (a <= opnd_b);
         CMP_GTU: cmp_true = (a >  opnd_b);
         CMP_GEU: cmp_true = (a >= opnd_b);
         default: cmp_true = 1'b0;
      endcase
   end

   always_comb begin
      op_res  = '0;
      op_pred = 1'b0;
      case (op)
         ADD:  op_res = a + opnd_b;
         SUB:  op_res = a - opnd_b;
         MUL:  op_res = a * opnd_b;
         FADD: op_res = fadd_res;
         FSUB: op_res = fsub_res;
         FMUL: op_res = fmul_res;
         AND:  op_res = a & opnd_b;
         OR:   op_res = a | opnd_b;
         XOR:  op_res = a ^ opnd_b;
         NOT:  op_res = ~a;
         CMP: begin
            op_pred = cmp_true;
            op_res  = {{(WIDTH-1){1'b0}}, cmp_true};
         end
         default: ;
      endcase
   end

   // Inactive lanes forward C so a masked write leaves the destination unchanged.
   assign result = mask ? op_res : c;
   assign pred   = mask & op_pred;

endmodule

// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: two-stage valid/ready vector ALU.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand beat handshake
//   in_op, in_cmp         : opcode (valu_op_e) and compare condition
//   in_use_c              : second operand is C instead of B
//   in_mask               : per-lane enable
//   in_a, in_b, in_c      : packed lane operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready : result beat handshake
//   out_result, out_pred  : packed lane results and per-lane predicates
// S1 holds the operands, the lanes compute combinationally from S1, S2 holds
// the results. Each stage advances when the stage after it is empty or draining.
module vector_alu_pipe
   import vector_alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_LANES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_op,
   input  logic [3:0]                 in_cmp,
   input  logic                       in_use_c,
   input  logic [NUM_LANES-1:0]       in_mask,
   input  logic [NUM_LANES*WIDTH-1:0] in_a,
   input  logic [NUM_LANES*WIDTH-1:0] in_b,
   input  logic [NUM_LANES*WIDTH-1:0] in_c,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_LANES*WIDTH-1:0] out_result,
   output logic [NUM_LANES-1:0]       out_pred
);

   logic                       s1_valid, s2_valid;
   valu_op_e                   s1_op;
   logic [3:0]                 s1_cmp;
   logic                       s1_use_c;
   logic [NUM_LANES-1:0]       s1_mask;
   logic [NUM_LANES*WIDTH-1:0] s1_a, s1_b, s1_c;
   logic [NUM_LANES*WIDTH-1:0] s2_result;
   logic [NUM_LANES-1:0]       s2_pred;
   logic [NUM_LANES*WIDTH-1:0] lane_result;
   logic [NUM_LANES-1:0]       lane_pred;
   logic                       init_done;
   logic                       s1_en, s2_en, accept;

   assign s2_en  = !s2_valid || out_ready;
   assign s1_en  = !s1_valid || s2_en;
   // init_done keeps the input closed until the first clock after reset release.
   assign in_ready = init_done && s1_en;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_done <= 1'b0;
         s1_valid  <= 1'b0;
         s1_op     <= ADD;
         s1_cmp    <= '0;
         s1_use_c  <= 1'b0;
         s1_mask   <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_c      <= '0;
      end else begin
         init_done <= 1'b1;
         if (s1_en) s1_valid <= accept;
         if (accept) begin
            s1_op    <= valu_op_e'(in_op);
            s1_cmp   <= in_cmp;
            s1_use_c <= in_use_c;
            s1_mask  <= in_mask;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_c     <= in_c;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         valu_lane #(.WIDTH(WIDTH)) u_lane (
            .op     (s1_op),
            .cmp    (s1_cmp),
            .use_c  (s1_use_c),
            .mask   (s1_mask[gi]),
            .a      (s1_a[lane_lsb(gi, WIDTH) +: WIDTH]),
            .b      (s1_b[lane_lsb(gi, WIDTH) +: WIDTH]),
            .c      (s1_c[lane_lsb(gi, WIDTH) +: WIDTH]),
            .result (lane_result[lane_lsb(gi, WIDTH) +: WIDTH]),
            .pred   (lane_pred[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_pred   <= '0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         // Only load on a real beat so the outputs hold their last value when idle.
         if (s1_valid) begin
            s2_result <= lane_result;
            s2_pred   <= lane_pred;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;
   assign out_pred   = s2_pred;

endmodule

// File: tb/tb_vector_alu_pipe.sv
module tb_vector_alu_pipe;
   localparam int W = 32;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_op = '0;
   logic [3:0]   in_cmp = '0;
   logic         in_use_c = 1'b0;
   logic [L-1:0] in_mask = '0;
   logic [L*W-1:0] in_a = '0, in_b = '0, in_c = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [L*W-1:0] out_result;
   logic [L-1:0] out_pred;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vector_alu_pipe #(.WIDTH(W), .NUM_LANES(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_cmp(in_cmp), .in_use_c(in_use_c), .in_mask(in_mask),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_pred(out_pred)
   );

   typedef struct {
      logic [3:0]     op;
      logic [3:0]     cmp;
      logic           use_c;
      logic [L-1:0]   mask;
      logic [L*W-1:0] a, b, c;
   } beat_t;

   typedef struct {
      logic [L*W-1:0] res;
      logic [L-1:0]   pred;
   } exp_t;

   // ---------------- reference model ----------------
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'h00) d = {f[31], 63'd0};
      else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Exact conversion: the stimulus only produces values representable in fp32.
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
   endfunction

   function automatic void model_lane(input int op, input int cmp, input logic [31:0] a,
         input logic [31:0] b, input logic [31:0] c, input bit use_c, input bit m,
         output logic [31:0] r, output bit p);
      logic [31:0] y;
      int sa, sy;
      y  = use_c ? c : b;
      sa = int'(a);
      sy = int'(y);
      r = 32'd0;
      p = 1'b0;
      case (op)
         0:  r = a + y;
         1:  r = a - y;
         2:  r = a * y;
         3:  r = r2f(f2r(a) + f2r(y));
         4:  r = r2f(f2r(a) - f2r(y));
         5:  r = r2f(f2r(a) * f2r(y));
         6:  r = a & y;
         7:  r = a | y;
         8:  r = a ^ y;
         9:  r = ~a;
         10: begin
            case (cmp)
               0: p = (a == y);
               1: p = (a != y);
               2: p = (sa <  sy);
               3: p = (sa <= sy);
               4: p = (sa >  sy);
               5: p = (sa >= sy);
               6: p = (a <  y);
               7: p = (a <= y);
               8: p = (a >  y);
               9: p = (a >= y);
               default: p = 1'b0;
            endcase
            r = {31'd0, p};
         end
         default: r = 32'd0;
      endcase
      if (!m) begin
         r = c;
         p = 1'b0;
      end
   endfunction

   function automatic exp_t model(input beat_t bt);
      exp_t e;
      logic [31:0] r;
      bit p;
      for (int i = 0; i < L; i++) begin
         model_lane(int'(bt.op), int'(bt.cmp), bt.a[i*W +: W], bt.b[i*W +: W], bt.c[i*W +: W],
                    bt.use_c, bt.mask[i], r, p);
         e.res[i*W +: W] = r;
         e.pred[i] = p;
      end
      return e;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [L*W-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                            input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic beat_t blank_beat();
      beat_t bt;
      bt.op = '0; bt.cmp = '0; bt.use_c = 1'b0; bt.mask = '0;
      bt.a = '0; bt.b = '0; bt.c = '0;
      return bt;
   endfunction

   // Small integer times a small power of two: sums and products stay exact in fp32.
   function automatic logic [31:0] fp_rand();
      real r;
      int  e;
      r = real'(int'($urandom_range(0, 510)) - 255);
      e = int'($urandom_range(0, 8)) - 4;
      for (int k = 0; k < e; k++) r = r * 2.0;
      for (int k = 0; k > e; k--) r = r / 2.0;
      return r2f(r);
   endfunction

   function automatic beat_t gen_beat();
      beat_t bt;
      bt.op    = 4'($urandom_range(0, 12));
      bt.cmp   = 4'($urandom_range(0, 10));
      bt.use_c = 1'($urandom_range(0, 1));
      bt.mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      for (int i = 0; i < L; i++) begin
         if (bt.op >= 4'd3 && bt.op <= 4'd5) begin
            bt.a[i*W +: W] = fp_rand();
            bt.b[i*W +: W] = fp_rand();
            bt.c[i*W +: W] = fp_rand();
         end else begin
            bt.a[i*W +: W] = $urandom;
            bt.b[i*W +: W] = ($urandom_range(0, 3) == 0) ? bt.a[i*W +: W] : $urandom;
            bt.c[i*W +: W] = ($urandom_range(0, 3) == 0) ? bt.a[i*W +: W] : $urandom;
         end
      end
      return bt;
   endfunction

   // One clock: drive on the falling edge, sample 1 time unit later.
   task automatic cycle(input logic drv_v, input beat_t bt, input logic ordy,
                        output logic acc, output logic drained, output logic irdy,
                        output logic [L*W-1:0] res, output logic [L-1:0] pred);
      @(negedge clk);
      in_valid  = drv_v;
      in_op     = bt.op;
      in_cmp    = bt.cmp;
      in_use_c  = bt.use_c;
      in_mask   = bt.mask;
      in_a      = bt.a;
      in_b      = bt.b;
      in_c      = bt.c;
      out_ready = ordy;
      #1;
      irdy    = in_ready;
      acc     = in_valid && in_ready;
      drained = out_valid && ordy;
      res     = out_result;
      pred    = out_pred;
   endtask

   // Sends one beat into an empty pipe; reports result and cycles to out_valid (-1 on timeout).
   task automatic run_single(input beat_t bt, output logic [L*W-1:0] res,
                             output logic [L-1:0] pred, output int lat);
      logic acc, dr, irdy;
      logic [L*W-1:0] r;
      logic [L-1:0] p;
      int t;
      lat = -1; res = '0; pred = '0; acc = 1'b0; t = 0;
      while (!acc && t < 10) begin
         cycle(1'b1, bt, 1'b1, acc, dr, irdy, r, p);
         t++;
      end
      if (!acc) return;
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0, blank_beat(), 1'b1, acc, dr, irdy, r, p);
         if (dr) begin
            lat = k; res = r; pred = p;
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      beat_t b1, b2;
      exp_t  e1;
      logic acc, dr, irdy;
      logic [L*W-1:0] r;
      logic [L-1:0] p;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
      n_checks++; if (out_pred !== '0) begin n_fail++; $display("FAIL reset_out_pred: got %b expected 0", out_pred); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_plus1_in_ready: got %b expected 1", in_ready); end

      // Fill both stages with out_ready low, then reset mid-stream.
      b1 = gen_beat(); b2 = gen_beat(); e1 = model(b1);
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) cycle(1'b1, b1, 1'b0, acc, dr, irdy, r, p);
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) cycle(1'b1, b2, 1'b0, acc, dr, irdy, r, p);
      cycle(1'b0, blank_beat(), 1'b0, acc, dr, irdy, r, p);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b expected 1", out_valid); end
      n_checks++; if (irdy !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", irdy); end
      n_checks++; if (r !== e1.res) begin n_fail++; $display("FAIL full_result: got %h expected %h", r, e1.res); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL midreset_out_result: got %h expected 0", out_result); end
      n_checks++; if (out_pred !== '0) begin n_fail++; $display("FAIL midreset_out_pred: got %b expected 0", out_pred); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, blank_beat(), 1'b1, acc, dr, irdy, r, p);
         n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL stale_beat cycle %0d: got out_valid %b expected 0", k, dr); end
      end
      $display("reset test done");
   endtask

   task automatic test_add_sub();
      beat_t bt;
      logic [L*W-1:0] r;
      logic [L-1:0] p;
      int lat;
      bt = blank_beat();
      bt.mask = 4'hF;
      bt.a = pack4(32'd1, 32'd7, 32'hFFFF_FFFF, 32'd5);
      bt.b = pack4(32'd2, 32'd3, 32'd1, 32'd5);
      bt.c = pack4(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
      bt.op = 4'd0;
      run_single(bt, r, p, lat);
      $display("ADD res=%h pred=%b lat=%0d", r, p, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
      n_checks++; if (r !== pack4(32'd3, 32'd10, 32'd0, 32'd10)) begin n_fail++; $display("FAIL add_result: got %h expected %h", r, pack4(32'd3, 32'd10, 32'd0, 32'd10)); end
      n_checks++; if (p !== 4'b0000) begin n_fail++; $display("FAIL add_pred: got %b expected 0000", p); end
      bt.op = 4'd1;
      run_single(bt, r, p, lat);
      $display("SUB res=%h pred=%b lat=%0d", r, p, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sub_latency: got %0d expected 2", lat); end
      n_checks++; if (r !== pack4(32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFE, 32'd0)) begin n_fail++; $display("FAIL sub_result: got %h expected %h", r, pack4(32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFE, 32'd0)); end
   endtask

   task automatic test_fp_mask();
      beat_t bt;
      logic [L*W-1:0] r, e;
      logic [L-1:0] p;
      int lat;
      bt = blank_beat();
      bt.op = 4'd5;
      bt.mask = 4'b0101;
      bt.a = {4{32'h4000_0000}};
      bt.b = {4{32'h3FC0_0000}};
      bt.c = pack4(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
      e = pack4(32'h4040_0000, 32'hDEAD_0001, 32'h4040_0000, 32'hDEAD_0003);
      run_single(bt, r, p, lat);
      $display("FMUL res=%h pred=%b lat=%0d", r, p, lat);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL fmul_mask_result: got %h expected %h", r, e); end
      n_checks++; if (p !== 4'b0000) begin n_fail++; $display("FAIL fmul_mask_pred: got %b expected 0000", p); end
   endtask

   task automatic test_cmp();
      beat_t bt;
      logic [L*W-1:0] r;
      logic [L-1:0] p;
      int lat;
      bt = blank_beat();
      bt.op = 4'd10;
      bt.cmp = 4'd0;
      bt.use_c = 1'b1;
      bt.mask = 4'hF;
      bt.a = pack4(32'd5, 32'd5, 32'd9, 32'd1);
      bt.b = pack4($urandom, $urandom, $urandom, $urandom);
      bt.c = pack4(32'd5, 32'd6, 32'd2, 32'd1);
      run_single(bt, r, p, lat);
      $display("CMP res=%h pred=%b lat=%0d", r, p, lat);
      n_checks++; if (p !== 4'b1001) begin n_fail++; $display("FAIL cmp_pred: got %b expected 1001", p); end
      n_checks++; if (r !== pack4(32'd1, 32'd0, 32'd0, 32'd1)) begin n_fail++; $display("FAIL cmp_result: got %h expected %h", r, pack4(32'd1, 32'd0, 32'd0, 32'd1)); end
   endtask

   task automatic test_backpressure();
      beat_t bp[6];
      exp_t  q[$];
      exp_t  e;
      logic acc, dr, irdy, ordy, exp_irdy;
      logic [L*W-1:0] r;
      logic [L-1:0] p;
      int sent, got, occ;
      for (int i = 0; i < 6; i++) bp[i] = gen_beat();
      sent = 0; got = 0; occ = 0;
      for (int c = 0; c < 80 && got < 6; c++) begin
         ordy = (c % 3 == 0);
         exp_irdy = !(occ == 2 && !ordy);
         cycle(sent < 6, bp[(sent < 6) ? sent : 5], ordy, acc, dr, irdy, r, p);
         n_checks++; if (irdy !== exp_irdy) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b expected %b", c, irdy, exp_irdy); end
         if (dr) begin
            if (q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL bp_extra_beat cycle %0d: got result %h expected no beat", c, r);
            end else begin
               e = q.pop_front();
               $display("bp beat %0d res=%h pred=%b", got, r, p);
               n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL bp_result beat %0d: got %h expected %h", got, r, e.res); end
               n_checks++; if (p !== e.pred) begin n_fail++; $display("FAIL bp_pred beat %0d: got %b expected %b", got, p, e.pred); end
            end
            got++; occ--;
         end
         if (acc) begin
            q.push_back(model(bp[sent]));
            sent++; occ++;
         end
      end
      n_checks++; if (got !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got); end
   endtask

   task automatic test_full_rate();
      beat_t bt[100];
      exp_t  q[$];
      exp_t  e;
      logic acc, dr, irdy, exp_ov;
      logic [L*W-1:0] r;
      logic [L-1:0] p;
      int sent, got;
      for (int i = 0; i < 100; i++) bt[i] = gen_beat();
      sent = 0; got = 0;
      for (int c = 0; c < 104; c++) begin
         cycle(sent < 100, bt[(sent < 100) ? sent : 99], 1'b1, acc, dr, irdy, r, p);
         exp_ov = (c >= 2 && c < 102);
         n_checks++; if (dr !== exp_ov) begin n_fail++; $display("FAIL fr_out_valid cycle %0d: got %b expected %b", c, dr, exp_ov); end
         if (c < 100) begin
            n_checks++; if (irdy !== 1'b1) begin n_fail++; $display("FAIL fr_in_ready cycle %0d: got %b expected 1", c, irdy); end
         end
         if (dr && q.size() > 0) begin
            e = q.pop_front();
            $display("fr beat %0d op=%0d res=%h pred=%b", got, bt[got].op, r, p);
            n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL fr_result beat %0d: got %h expected %h", got, r, e.res); end
            n_checks++; if (p !== e.pred) begin n_fail++; $display("FAIL fr_pred beat %0d: got %b expected %b", got, p, e.pred); end
            got++;
         end
         if (acc) begin
            q.push_back(model(bt[sent]));
            sent++;
         end
      end
      n_checks++; if (got !== 100) begin n_fail++; $display("FAIL fr_count: got %0d expected 100", got); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add_sub();
      test_fp_mask();
      test_cmp();
      test_backpressure();
      test_full_rate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
